// File: rtl/ex_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ex_pkg
// Brief    : Opcodes, stage state encoding and flag bit positions for EX/MEM.
// Revision : 1.0
// ============================================================================
package ex_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0010;
    localparam logic [3:0] OP_AND = 4'b0011;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRA = 4'b0101;
    localparam logic [3:0] OP_ROR = 4'b0110;
    localparam logic [3:0] OP_OR  = 4'b0111;
    localparam logic [3:0] OP_LW  = 4'b1000;
    localparam logic [3:0] OP_SW  = 4'b1001;
    localparam logic [3:0] OP_BR  = 4'b1100;
    localparam logic [3:0] OP_HLT = 4'b1111;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } ex_state_t;

    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

endpackage
`default_nettype wire

// File: rtl/ex_flag_stage_flag_unit.sv
`default_nettype none
// ============================================================================
// Module   : flag_unit
// Brief    : Combinational Z/V/N computation and per-opcode update mask.
// Revision : 1.0
// ============================================================================
module flag_unit
    import ex_pkg::*;
(
    input  logic [3:0]  i_opcode,
    input  logic [15:0] i_result,
    input  logic        i_ovf,
    input  logic [2:0]  i_flags_q,
    output logic [2:0]  o_flags_next,
    output logic [2:0]  o_update_mask
);

    logic [2:0] w_calc;
    logic [2:0] w_mask;

    always_comb begin
        w_calc         = 3'b000;
        w_calc[FLAG_Z] = (i_result == 16'h0000);
        w_calc[FLAG_V] = i_ovf;
        w_calc[FLAG_N] = i_result[15];

        w_mask = 3'b000;
        case (i_opcode)
            OP_ADD, OP_SUB:                 w_mask = 3'b111;
            OP_XOR, OP_SLL, OP_SRA, OP_ROR: w_mask[FLAG_Z] = 1'b1;
            default:                        w_mask = 3'b000;
        endcase
    end

    // Masked bits take the fresh value, the rest keep the architectural flags.
    assign o_flags_next  = (w_calc & w_mask) | (i_flags_q & ~w_mask);
    assign o_update_mask = w_mask;

endmodule
`default_nettype wire

// File: rtl/ex_flag_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_flag_stage
// Brief    : EX/MEM pipeline register, Z/V/N flag register and HLT drain FSM.
// Revision : 1.0
// ============================================================================
module ex_flag_stage
    import ex_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [3:0]  ex_opcode,
    input  logic [15:0] ex_result,
    input  logic        ex_ovf,
    input  logic [3:0]  ex_rd,
    input  logic        ex_wr_en,
    input  logic        stall,
    input  logic        flush,
    output logic        mem_valid,
    output logic [3:0]  mem_opcode,
    output logic [15:0] mem_result,
    output logic [3:0]  mem_rd,
    output logic        mem_wr_en,
    output logic [2:0]  flags_q,
    output logic [2:0]  flags_fwd,
    output logic        halted
);

    ex_state_t   r_state;
    ex_state_t   w_state_nxt;
    logic        w_accept;
    logic [2:0]  w_flags_next;
    logic [2:0]  w_update_mask;

    logic        r_valid;
    logic [3:0]  r_opcode;
    logic [15:0] r_result;
    logic [3:0]  r_rd;
    logic        r_wr_en;
    logic [2:0]  r_flags;

    assign w_accept = ex_valid & ~flush & ~stall & (r_state == RUN);

    flag_unit u_flag_unit (
        .i_opcode      (ex_opcode),
        .i_result      (ex_result),
        .i_ovf         (ex_ovf),
        .i_flags_q     (r_flags),
        .o_flags_next  (w_flags_next),
        .o_update_mask (w_update_mask)
    );

    // Data fields keep their last value on a bubble; only valid/wr_en drop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid  <= 1'b0;
            r_opcode <= 4'h0;
            r_result <= 16'h0000;
            r_rd     <= 4'h0;
            r_wr_en  <= 1'b0;
        end else if (!stall) begin
            if (w_accept) begin
                r_valid  <= 1'b1;
                r_opcode <= ex_opcode;
                r_result <= ex_result;
                r_rd     <= ex_rd;
                r_wr_en  <= ex_wr_en;
            end else begin
                r_valid  <= 1'b0;
                r_wr_en  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flags <= 3'b000;
        end else if (w_accept && (w_update_mask != 3'b000)) begin
            r_flags <= w_flags_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN: begin
                if (w_accept && (ex_opcode == OP_HLT)) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (!stall) begin
                    w_state_nxt = HALTED;
                end
            end
            HALTED:  w_state_nxt = HALTED;
            default: w_state_nxt = RUN;
        endcase
    end

    assign flags_fwd  = w_accept ? w_flags_next : r_flags;
    assign flags_q    = r_flags;
    assign halted     = (r_state == HALTED);
    assign mem_valid  = r_valid;
    assign mem_opcode = r_opcode;
    assign mem_result = r_result;
    assign mem_rd     = r_rd;
    assign mem_wr_en  = r_wr_en;

endmodule
`default_nettype wire

// File: tb/tb_ex_flag_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_flag_stage
// Brief    : Scoreboard bench for ex_flag_stage with hand-computed vectors.
// Revision : 1.0
// ============================================================================
module tb_ex_flag_stage;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic [3:0]  ex_opcode;
    logic [15:0] ex_result;
    logic        ex_ovf;
    logic [3:0]  ex_rd;
    logic        ex_wr_en;
    logic        stall;
    logic        flush;
    logic        mem_valid;
    logic [3:0]  mem_opcode;
    logic [15:0] mem_result;
    logic [3:0]  mem_rd;
    logic        mem_wr_en;
    logic [2:0]  flags_q;
    logic [2:0]  flags_fwd;
    logic        halted;

    typedef struct packed {
        logic [2:0]  fwd;
        logic        valid;
        logic [3:0]  op;
        logic [15:0] res;
        logic [3:0]  rd;
        logic        we;
        logic [2:0]  flags;
        logic        halted;
    } exp_t;

    exp_t sb[$];
    int   errors   = 0;
    int   checks   = 0;
    bit   mon_busy = 1'b0;

    ex_flag_stage dut (
        .clk        (clk),
        .rst        (rst),
        .ex_valid   (ex_valid),
        .ex_opcode  (ex_opcode),
        .ex_result  (ex_result),
        .ex_ovf     (ex_ovf),
        .ex_rd      (ex_rd),
        .ex_wr_en   (ex_wr_en),
        .stall      (stall),
        .flush      (flush),
        .mem_valid  (mem_valid),
        .mem_opcode (mem_opcode),
        .mem_result (mem_result),
        .mem_rd     (mem_rd),
        .mem_wr_en  (mem_wr_en),
        .flags_q    (flags_q),
        .flags_fwd  (flags_fwd),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of stimulus at the falling edge and queue its expectation.
    task automatic step(input logic v, input logic [3:0] op, input logic [15:0] res,
                        input logic ovf, input logic [3:0] rd, input logic we,
                        input logic st, input logic fl,
                        input logic [2:0] e_fwd, input logic e_valid, input logic [3:0] e_op,
                        input logic [15:0] e_res, input logic [3:0] e_rd, input logic e_we,
                        input logic [2:0] e_flags, input logic e_halted);
        exp_t e;
        @(negedge clk);
        ex_valid  = v;
        ex_opcode = op;
        ex_result = res;
        ex_ovf    = ovf;
        ex_rd     = rd;
        ex_wr_en  = we;
        stall     = st;
        flush     = fl;
        e.fwd     = e_fwd;
        e.valid   = e_valid;
        e.op      = e_op;
        e.res     = e_res;
        e.rd      = e_rd;
        e.we      = e_we;
        e.flags   = e_flags;
        e.halted  = e_halted;
        sb.push_back(e);
    endtask

    // Monitor: flags_fwd sampled mid-cycle, registered outputs just after the edge.
    initial begin
        exp_t e;
        exp_t act;
        int   idx;
        idx = 0;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() > 0) begin
                mon_busy = 1'b1;
                e = sb.pop_front();
                idx++;
                check($sformatf("fwd[%0d]", idx), {61'd0, flags_fwd}, {61'd0, e.fwd});
                @(posedge clk);
                #1;
                act = {e.fwd, mem_valid, mem_opcode, mem_result, mem_rd, mem_wr_en, flags_q, halted};
                check($sformatf("regs[%0d]", idx), {31'd0, act}, {31'd0, e});
                mon_busy = 1'b0;
            end
        end
    end

    task automatic check_cleared(input string name);
        check({name, "_valid"},  {63'd0, mem_valid},  64'd0);
        check({name, "_wr_en"},  {63'd0, mem_wr_en},  64'd0);
        check({name, "_opcode"}, {60'd0, mem_opcode}, 64'd0);
        check({name, "_result"}, {48'd0, mem_result}, 64'd0);
        check({name, "_rd"},     {60'd0, mem_rd},     64'd0);
        check({name, "_flags"},  {61'd0, flags_q},    64'd0);
        check({name, "_halted"}, {63'd0, halted},     64'd0);
    endtask

    initial begin
        int wait_cycles;
        rst = 1'b1; ex_valid = 1'b0; ex_opcode = 4'h0; ex_result = 16'h0;
        ex_ovf = 1'b0; ex_rd = 4'h0; ex_wr_en = 1'b0; stall = 1'b0; flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_cleared("reset_held");
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_cleared("reset_released");

        //    v  op       result   ovf rd     we st fl   fwd   val op     result   rd     we flags  hlt
        step(1, 4'b0000, 16'h8000, 1, 4'h1, 1, 0, 0, 3'b011, 1, 4'b0000, 16'h8000, 4'h1, 1, 3'b011, 0); // ADD
        step(1, 4'b0100, 16'h0000, 1, 4'h2, 1, 0, 0, 3'b111, 1, 4'b0100, 16'h0000, 4'h2, 1, 3'b111, 0); // SLL
        step(1, 4'b1000, 16'h0000, 0, 4'h3, 1, 0, 0, 3'b111, 1, 4'b1000, 16'h0000, 4'h3, 1, 3'b111, 0); // LW
        step(1, 4'b0001, 16'h0005, 0, 4'h4, 1, 0, 0, 3'b000, 1, 4'b0001, 16'h0005, 4'h4, 1, 3'b000, 0); // SUB
        step(1, 4'b0010, 16'h0000, 1, 4'h5, 1, 0, 0, 3'b100, 1, 4'b0010, 16'h0000, 4'h5, 1, 3'b100, 0); // XOR
        step(1, 4'b0000, 16'h8000, 1, 4'h6, 1, 1, 0, 3'b100, 1, 4'b0010, 16'h0000, 4'h5, 1, 3'b100, 0); // stall
        step(1, 4'b0000, 16'h8000, 1, 4'h6, 1, 1, 1, 3'b100, 1, 4'b0010, 16'h0000, 4'h5, 1, 3'b100, 0); // stall+flush
        step(1, 4'b0000, 16'h8000, 1, 4'h6, 1, 1, 0, 3'b100, 1, 4'b0010, 16'h0000, 4'h5, 1, 3'b100, 0); // stall
        step(1, 4'b0000, 16'h0000, 0, 4'h7, 1, 0, 1, 3'b100, 0, 4'b0010, 16'h0000, 4'h5, 0, 3'b100, 0); // flush ADD
        step(0, 4'b0000, 16'h0000, 0, 4'h7, 1, 0, 0, 3'b100, 0, 4'b0010, 16'h0000, 4'h5, 0, 3'b100, 0); // bubble
        step(1, 4'b0101, 16'hFFFF, 1, 4'h8, 1, 0, 0, 3'b000, 1, 4'b0101, 16'hFFFF, 4'h8, 1, 3'b000, 0); // SRA
        step(1, 4'b0110, 16'h0000, 0, 4'h9, 0, 0, 0, 3'b100, 1, 4'b0110, 16'h0000, 4'h9, 0, 3'b100, 0); // ROR
        step(1, 4'b0000, 16'h7FFF, 0, 4'hA, 1, 0, 0, 3'b000, 1, 4'b0000, 16'h7FFF, 4'hA, 1, 3'b000, 0); // ADD
        step(1, 4'b1111, 16'h0000, 0, 4'h0, 0, 0, 1, 3'b000, 0, 4'b0000, 16'h7FFF, 4'hA, 0, 3'b000, 0); // HLT flushed
        step(1, 4'b1111, 16'h0000, 0, 4'h0, 0, 0, 0, 3'b000, 1, 4'b1111, 16'h0000, 4'h0, 0, 3'b000, 0); // HLT
        step(1, 4'b0000, 16'h8000, 1, 4'hB, 1, 0, 0, 3'b000, 0, 4'b1111, 16'h0000, 4'h0, 0, 3'b000, 1); // ADD dropped
        step(1, 4'b0001, 16'h0000, 1, 4'hC, 1, 0, 0, 3'b000, 0, 4'b1111, 16'h0000, 4'h0, 0, 3'b000, 1); // still halted

        @(negedge clk);
        ex_valid = 1'b0;
        stall    = 1'b1;
        wait_cycles = 0;
        while ((sb.size() > 0 || mon_busy) && wait_cycles < 20) begin
            @(posedge clk);
            #2;
            wait_cycles++;
        end
        check("drain_timeout", {63'd0, (sb.size() > 0 || mon_busy)}, 64'd0);

        // Reset lands between clock edges while halted and stalled.
        @(negedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_cleared("async_reset");
        check("async_reset_fwd", {61'd0, flags_fwd}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ex_flag_stage.md
# ex_flag_stage

Execute-to-memory boundary stage of the 16-bit pipeline. It registers the execute-stage result (including shifter output) into the EX/MEM pipeline register, owns the architectural Z/V/N flag register with per-opcode update rules, and tracks HLT so the pipeline drains and stops. It sits directly downstream of the ALU/shifter and feeds the memory stage and the branch-resolution logic.

## Interface
- No parameters. Data width is fixed at 16 and the register index width at 4.
- clk  in  1  pipeline clock; every register updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- ex_valid  in  1  an execute-stage instruction is present this cycle.
- ex_opcode  in  4  opcode of that instruction.
- ex_result  in  16  ALU/shifter result.
- ex_ovf  in  1  signed overflow from the adder, meaningful only for ADD/SUB.
- ex_rd  in  4  destination register.
- ex_wr_en  in  1  the instruction writes ex_rd.
- stall  in  1  the memory stage cannot accept; hold all state.
- flush  in  1  squash the incoming instruction.
- mem_valid  out  1  registered valid.
- mem_opcode  out  4  registered opcode.
- mem_result  out  16  registered result.
- mem_rd  out  4  registered destination register.
- mem_wr_en  out  1  registered write enable, forced to 0 when the stage is invalid.
- flags_q  out  3  architectural flags {Z,V,N}.
- flags_fwd  out  3  flags including the update from the current ex instruction. Combinational; used by a branch in decode.
- halted  out  1  pipeline has fully stopped after HLT.

## Operation
- Accept condition: accept = ex_valid & ~flush & ~stall & (state==RUN).
- On accept, the pipeline register loads {opcode,result,rd,wr_en} and mem_valid becomes 1.
- When not stalled and not accepting, mem_valid becomes 0 and mem_wr_en becomes 0. The data fields hold their last value.
- When stall=1, every register holds, including the flags and the FSM. Stall takes priority over flush.
- Flags are computed locally. Z = (ex_result == 16'h0000). N = ex_result[15]. V = ex_ovf. The upstream Z is not used.
- Flag update rules, applied only on accept:
  - ADD 0000 and SUB 0001 update Z, V and N.
  - XOR 0010, SLL 0100, SRA 0101 and ROR 0110 update Z only.
  - All other opcodes leave the flags unchanged.
- flags_fwd equals the post-update value when accept is true this cycle, otherwise flags_q.
- FSM states:
  - RUN: on accept of HLT 1111, go to DRAIN.
  - DRAIN: no new instruction is accepted, and any ex_valid is dropped. When not stalled, go to HALTED the next cycle, which gives the HLT one cycle in mem.
  - HALTED: terminal state; only reset leaves it. halted=1.
- A flush in the same cycle as HLT squashes the HLT, and the state stays RUN.

## Timing
- Latency is 1 cycle from ex_* to mem_*. flags_fwd is 0-cycle combinational; flags_q lags it by 1 cycle.
- Reset values: mem_valid=0, mem_wr_en=0, mem_opcode=0, mem_result=0, mem_rd=0, flags_q=3'b000, state=RUN, halted=0.
- Reset asserted mid-DRAIN or mid-stall returns all outputs to reset values immediately, without waiting for a clock edge.
- HLT accepted at edge k: mem_opcode=1111 after k, and halted=1 after k+1 provided there is no stall.
- Back-to-back flag-setting instructions: each one sees the flags from its predecessor through flags_fwd, with no bubble.

## Structure
- Shared package ex_pkg holds:
  - the 4-bit opcode constants (ADD through HLT);
  - the state enum {RUN, DRAIN, HALTED};
  - the flag bit indices FLAG_Z=2, FLAG_V=1, FLAG_N=0.
- One sub-module, flag_unit, is combinational. Its inputs are opcode, result, ovf and flags_q; its outputs are the next flags and the update mask.
- The pipeline register, FSM and flag register stay in ex_flag_stage.

## Test plan
- Reset: hold rst high, then release. All outputs are 0, and flags_q=000.
- ADD result 16'h8000 with ovf=1, accepted:
  - flags_fwd=011 in the same cycle;
  - flags_q=011 and mem_result=8000 at the next edge.
- SLL result 0000 following that ADD: only Z is updated, so flags_q=111. Then an LW with result 0000 leaves flags_q=111.
- Stall with ex_valid=1 for 3 cycles: mem_* and flags_q are held. A simultaneous flush=1 during the stall has no effect.
- Flush with an ADD present: mem_valid=0, mem_wr_en=0 and the flags are unchanged at the next edge.
- HLT accepted, followed by ADD on the next cycle:
  - mem_opcode=1111 after 1 edge;
  - the ADD is dropped and the flags are unchanged;
  - halted=1 after 2 edges.
  - Asserting rst afterwards clears halted asynchronously.
